// File: rtl/coax_line_arbiter.sv
// -----------------------------------------------------------------------------
// coax_line_arbiter
//
// Half-duplex ownership controller for the single coax conductor shared by the
// transmitter and the coax_rx receive path. It grants the transmitter, masks
// the receiver while transmitting and during turnaround, opens a bounded
// response window after a transmission that expects a reply, and reports
// response timeouts.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous, active-high reset
//   tx_request      in   host wants to transmit (level, held until tx_grant)
//   tx_done         in   one-clock pulse at the end of the transmitted frame
//   expect_response in   sampled with tx_done; 1 opens a response window
//   rx_active       in   receiver is currently receiving a frame (level)
//   stats_clear     in   (stats build only) synchronous clear of timeout_count
//   tx_grant        out  transmitter may drive the line
//   rx_enable       out  receiver may accept frames
//   busy            out  arbiter is not idle
//   timeout_count   out  (stats build only) saturating count of rx_timeout
//   rx_timeout      out  one-clock pulse when the response window expires
//
// Optional feature: define COAX_LINE_ARBITER_STATS_EN to add the timeout
// statistics counter and its clear input.
//
// Every output is registered. Level outputs are decoded from the current
// state register, so they follow a state change by one clock. rx_timeout is
// registered from the expiry event itself, so it is high for the single clock
// after the edge on which RESP_WAIT hands back to IDLE.
// -----------------------------------------------------------------------------
module coax_line_arbiter #(
   parameter int CLOCKS_PER_BIT        = 8,
   parameter int TURNAROUND_BITS       = 4,
   parameter int RESPONSE_TIMEOUT_BITS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_request,
   input  logic       tx_done,
   input  logic       expect_response,
   input  logic       rx_active,
`ifdef COAX_LINE_ARBITER_STATS_EN
   input  logic       stats_clear,
   output logic [7:0] timeout_count,
`endif
   output logic       tx_grant,
   output logic       rx_enable,
   output logic       busy,
   output logic       rx_timeout
);

   localparam int MAX_BITS = (TURNAROUND_BITS > RESPONSE_TIMEOUT_BITS) ?
                             TURNAROUND_BITS : RESPONSE_TIMEOUT_BITS;
   localparam int CNT_W    = $clog2(MAX_BITS * CLOCKS_PER_BIT + 1);

   // Load values are N*CLOCKS_PER_BIT-1 so a timed state lasts exactly
   // N*CLOCKS_PER_BIT clocks including the terminal zero cycle.
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(TURNAROUND_BITS * CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESPONSE_TIMEOUT_BITS * CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TX        = 3'd1,
      ST_TX_GAP    = 3'd2,
      ST_RESP_WAIT = 3'd3,
      ST_RX        = 3'd4,
      ST_RX_GAP    = 3'd5
   } state_t;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             expect_q, expect_d;
   logic             timeout_d;
   logic             tx_grant_q, rx_enable_q, busy_q, rx_timeout_q;
   logic             tx_grant_d, rx_enable_d, busy_d;

   // Next-state, down-counter and output decode for the line FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      expect_d  = expect_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = CNT_ZERO;
            // Receiver wins when both sides want the line in the same cycle.
            if (rx_active) begin
               state_d = ST_RX;
            end else if (tx_request) begin
               state_d = ST_TX;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TX: begin
            if (tx_done) begin
               state_d  = ST_TX_GAP;
               cnt_d    = GAP_LOAD;
               expect_d = expect_response;
            end else begin
               state_d  = ST_TX;
            end
         end
         ST_TX_GAP: begin
            if (cnt_q == CNT_ZERO) begin
               if (expect_q) begin
                  state_d = ST_RESP_WAIT;
                  cnt_d   = RESP_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP_WAIT: begin
            // A response arriving on the terminal cycle still counts.
            if (rx_active) begin
               state_d = ST_RX;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_ZERO) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RX: begin
            if (!rx_active) begin
               state_d = ST_RX_GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               state_d = ST_RX;
            end
         end
         ST_RX_GAP: begin
            // A new frame cancels the quiet gap; tx_request is not looked at.
            if (rx_active) begin
               state_d = ST_RX;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      tx_grant_d  = (state_q == ST_TX);
      rx_enable_d = !((state_q == ST_TX) || (state_q == ST_TX_GAP));
      busy_d      = (state_q != ST_IDLE);
   end

   // State, counter and registered outputs; reset drops tx_grant immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         expect_q     <= 1'b0;
         tx_grant_q   <= 1'b0;
         rx_enable_q  <= 1'b1;
         busy_q       <= 1'b0;
         rx_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         expect_q     <= expect_d;
         tx_grant_q   <= tx_grant_d;
         rx_enable_q  <= rx_enable_d;
         busy_q       <= busy_d;
         rx_timeout_q <= timeout_d;
      end
   end

   assign tx_grant   = tx_grant_q;
   assign rx_enable  = rx_enable_q;
   assign busy       = busy_q;
   assign rx_timeout = rx_timeout_q;

`ifdef COAX_LINE_ARBITER_STATS_EN
   logic [7:0] timeout_count_q, timeout_count_d;

   // Saturating timeout counter; clear beats a same-cycle increment.
   always_comb begin
      if (stats_clear) begin
         timeout_count_d = 8'd0;
      end else if (timeout_d && (timeout_count_q != 8'd255)) begin
         timeout_count_d = timeout_count_q + 8'd1;
      end else begin
         timeout_count_d = timeout_count_q;
      end
   end

   // Timeout statistics register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_count_q <= 8'd0;
      end else begin
         timeout_count_q <= timeout_count_d;
      end
   end

   assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_coax_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_coax_line_arbiter
//
// Directed bench for coax_line_arbiter at default parameters (8 clocks/bit,
// 4-bit turnaround = 32 clocks, 64-bit response window = 512 clocks).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// With COAX_LINE_ARBITER_STATS_EN defined, a second instance with 1-clock
// timed states is used to reach counter saturation quickly.
// -----------------------------------------------------------------------------
module tb_coax_line_arbiter;

   logic clk;
   logic reset;
   logic tx_request;
   logic tx_done;
   logic expect_response;
   logic rx_active;
   logic tx_grant;
   logic rx_enable;
   logic busy;
   logic rx_timeout;

   int errors;
   int checks;

`ifdef COAX_LINE_ARBITER_STATS_EN
   logic       stats_clear;
   logic [7:0] timeout_count;
   logic       f_req, f_done, f_exp, f_rxa, f_clear;
   logic       f_grant, f_rxen, f_busy, f_timeout;
   logic [7:0] f_count;
`endif

   coax_line_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .tx_request      (tx_request),
      .tx_done         (tx_done),
      .expect_response (expect_response),
      .rx_active       (rx_active),
`ifdef COAX_LINE_ARBITER_STATS_EN
      .stats_clear     (stats_clear),
      .timeout_count   (timeout_count),
`endif
      .tx_grant        (tx_grant),
      .rx_enable       (rx_enable),
      .busy            (busy),
      .rx_timeout      (rx_timeout)
   );

`ifdef COAX_LINE_ARBITER_STATS_EN
   coax_line_arbiter #(
      .CLOCKS_PER_BIT        (1),
      .TURNAROUND_BITS       (1),
      .RESPONSE_TIMEOUT_BITS (1)
   ) dut_fast (
      .clk             (clk),
      .reset           (reset),
      .tx_request      (f_req),
      .tx_done         (f_done),
      .expect_response (f_exp),
      .rx_active       (f_rxa),
      .stats_clear     (f_clear),
      .timeout_count   (f_count),
      .tx_grant        (f_grant),
      .rx_enable       (f_rxen),
      .busy            (f_busy),
      .rx_timeout      (f_timeout)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bring the main DUT back to IDLE with a bounded wait.
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b required 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (tx_grant !== 1'b0 || rx_enable !== 1'b1 || busy !== 1'b0 || rx_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: grant=%b rxen=%b busy=%b tmo=%b required 0 1 0 0",
                  tx_grant, rx_enable, busy, rx_timeout);
      end
      reset = 1'b0;
      repeat (3) step();
      checks++;
      if (tx_grant !== 1'b0 || rx_enable !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_values: grant=%b rxen=%b busy=%b required 0 1 0",
                  tx_grant, rx_enable, busy);
      end
`ifdef COAX_LINE_ARBITER_STATS_EN
      checks++;
      if (timeout_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d required 0", timeout_count);
      end
`endif
   endtask

   task automatic test_tx_no_response();
      int n;
      int m;
      tx_request = 1'b1;
      step();
      checks++;
      if (tx_grant !== 1'b0) begin
         errors++;
         $display("FAIL grant_latency: grant=%b required 0 one edge after request", tx_grant);
      end
      step();
      checks++;
      if (tx_grant !== 1'b1) begin
         errors++;
         $display("FAIL grant_rise: grant=%b required 1 two edges after request", tx_grant);
      end
      tx_request = 1'b0;
      n = tx_grant ? 1 : 0;
      repeat (98) begin
         step();
         if (tx_grant) n++;
      end
      tx_done = 1'b1;
      expect_response = 1'b0;
      step();
      tx_done = 1'b0;
      if (tx_grant) n++;
      step();
      checks++;
      if (tx_grant !== 1'b0 || n != 100) begin
         errors++;
         $display("FAIL grant_width: grant=%b high_clocks=%0d required 0 and 100", tx_grant, n);
      end
      m = 0;
      while (!rx_enable && m < 200) begin
         step();
         m++;
      end
      checks++;
      if (m != 32) begin
         errors++;
         $display("FAIL tx_gap_len: rx_enable low %0d clocks after grant fell required 32", m);
      end
      checks++;
      if (busy !== 1'b0 || rx_timeout !== 1'b0) begin
         errors++;
         $display("FAIL tx_gap_end: busy=%b tmo=%b required 0 0", busy, rx_timeout);
      end
   endtask

   task automatic test_tx_timeout();
      int k;
      tx_request = 1'b1;
      step();
      step();
      tx_request = 1'b0;
      repeat (10) step();
      tx_done = 1'b1;
      expect_response = 1'b1;
      step();
      tx_done = 1'b0;
      expect_response = 1'b0;
      k = 0;
      while (!rx_timeout && k < 1000) begin
         step();
         k++;
      end
      checks++;
      if (k != 544) begin
         errors++;
         $display("FAIL timeout_delay: pulse %0d clocks after tx_done required 544", k);
      end
      checks++;
      if (rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL resp_rx_enable: rxen=%b required 1 during response window", rx_enable);
      end
`ifdef COAX_LINE_ARBITER_STATS_EN
      checks++;
      if (timeout_count !== 8'd1) begin
         errors++;
         $display("FAIL timeout_count_one: got %0d required 1", timeout_count);
      end
`endif
      step();
      checks++;
      if (rx_timeout !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: tmo=%b busy=%b next clock required 0 0", rx_timeout, busy);
      end
   endtask

   task automatic test_resp_late_rx();
      int j;
      int pulses;
      tx_request = 1'b1;
      step();
      step();
      tx_request = 1'b0;
      repeat (5) step();
      tx_done = 1'b1;
      expect_response = 1'b1;
      step();
      tx_done = 1'b0;
      expect_response = 1'b0;
      pulses = 0;
      repeat (543) begin
         step();
         if (rx_timeout) pulses++;
      end
      rx_active = 1'b1;
      repeat (6) begin
         step();
         if (rx_timeout) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b1 || rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL late_rx: timeouts=%0d busy=%b rxen=%b required 0 1 1", pulses, busy, rx_enable);
      end
      rx_active = 1'b0;
      tx_request = 1'b1;
      step();
      j = 0;
      while (!tx_grant && j < 200) begin
         step();
         j++;
      end
      checks++;
      if (j != 34) begin
         errors++;
         $display("FAIL rx_gap_grant: grant after %0d clocks required 34", j);
      end
      tx_request = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      wait_idle("late_rx");
   endtask

   task automatic test_rx_priority();
      int j;
      int grants;
      tx_request = 1'b1;
      rx_active = 1'b1;
      grants = 0;
      repeat (4) begin
         step();
         if (tx_grant) grants++;
      end
      checks++;
      if (grants != 0 || busy !== 1'b1 || rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL rx_priority: grants=%0d busy=%b rxen=%b required 0 1 1", grants, busy, rx_enable);
      end
      rx_active = 1'b0;
      step();
      j = 0;
      while (!tx_grant && j < 200) begin
         step();
         j++;
      end
      checks++;
      if (j != 34) begin
         errors++;
         $display("FAIL rx_priority_grant: grant after %0d clocks required 34", j);
      end
      tx_request = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      wait_idle("rx_priority");
   endtask

   task automatic test_tx_done_ignored();
      tx_done = 1'b1;
      expect_response = 1'b1;
      step();
      tx_done = 1'b0;
      expect_response = 1'b0;
      repeat (3) step();
      checks++;
      if (busy !== 1'b0 || tx_grant !== 1'b0 || rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL done_ignored: busy=%b grant=%b rxen=%b required 0 0 1", busy, tx_grant, rx_enable);
      end
   endtask

   task automatic test_reset_mid_tx();
      tx_request = 1'b1;
      step();
      step();
      tx_request = 1'b0;
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (tx_grant !== 1'b0 || rx_enable !== 1'b1 || busy !== 1'b0 || rx_timeout !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: grant=%b rxen=%b busy=%b tmo=%b required 0 1 0 0",
                  tx_grant, rx_enable, busy, rx_timeout);
      end
      step();
      reset = 1'b0;
      repeat (2) step();
      checks++;
      if (busy !== 1'b0 || tx_grant !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: busy=%b grant=%b required 0 0", busy, tx_grant);
      end
   endtask

`ifdef COAX_LINE_ARBITER_STATS_EN
   task automatic test_stats();
      int pulses;
      int n;
      f_req = 1'b1;
      f_done = 1'b1;
      f_exp = 1'b1;
      pulses = 0;
      n = 0;
      while (pulses < 300 && n < 3000) begin
         step();
         n++;
         if (f_timeout) pulses++;
      end
      checks++;
      if (pulses != 300 || f_count !== 8'd255) begin
         errors++;
         $display("FAIL stats_saturate: pulses=%0d count=%0d required 300 255", pulses, f_count);
      end
      repeat (3) step();
      f_clear = 1'b1;
      step();
      f_clear = 1'b0;
      checks++;
      if (f_timeout !== 1'b1 || f_count !== 8'd0) begin
         errors++;
         $display("FAIL stats_clear: tmo=%b count=%0d required 1 0", f_timeout, f_count);
      end
      repeat (4) step();
      checks++;
      if (f_count !== 8'd1) begin
         errors++;
         $display("FAIL stats_resume: count=%0d required 1", f_count);
      end
      f_req = 1'b0;
      f_done = 1'b0;
      f_exp = 1'b0;
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      tx_request = 1'b0;
      tx_done = 1'b0;
      expect_response = 1'b0;
      rx_active = 1'b0;
`ifdef COAX_LINE_ARBITER_STATS_EN
      stats_clear = 1'b0;
      f_req = 1'b0;
      f_done = 1'b0;
      f_exp = 1'b0;
      f_rxa = 1'b0;
      f_clear = 1'b0;
`endif
      test_reset();
      test_tx_no_response();
      test_tx_timeout();
      test_resp_late_rx();
      test_rx_priority();
      test_tx_done_ignored();
      test_reset_mid_tx();
`ifdef COAX_LINE_ARBITER_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
